// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating direction counters,
// combinational fetch lookup, and EX-stage resolve/redirect logic.
// Optional build macro BP_STATS_EN enables the branch / mispredict counters;
// without it the statistics ports are tied to zero.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_actual_target,
    input  logic [31:0] ex_pred_target,
    input  logic        ex_actual_taken,
    input  logic        ex_pred_taken,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    // Table storage: valid/ctr are reset, tag/target are payload only
    logic            valid_q [ENTRIES];
    logic [1:0]      ctr_q   [ENTRIES];
    logic [TAGW-1:0] tag_q   [ENTRIES];
    logic [31:0]     tgt_q   [ENTRIES];

    logic [IDX-1:0]  f_idx, ex_idx;
    logic [TAGW-1:0] f_tag, ex_tag;
    logic            f_hit, ex_hit;
    logic            eff_taken;
    logic            upd_br;
    logic [1:0]      ctr_d;

    assign f_idx  = fetch_pc[IDX+1:2];
    assign f_tag  = fetch_pc[31:IDX+2];
    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[31:IDX+2];

    // Fetch lookup reads pre-update contents, so a same-cycle write is seen next cycle
    always_comb begin
        f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        predict_taken  = f_hit && ctr_q[f_idx][1];
        predict_target = predict_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;
    end

    // Resolve: non-branches count as not-taken when judging the prediction
    always_comb begin
        ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        eff_taken  = ex_is_branch && ex_actual_taken;
        upd_br     = ex_valid && ex_is_branch;
        mispredict = ex_valid && ((eff_taken != ex_pred_taken) ||
                                  (eff_taken && (ex_actual_target != ex_pred_target)));
        correct_pc = eff_taken ? ex_actual_target : ex_pc + 32'd4;
    end

    // Saturating counter step for the resolving entry
    always_comb begin
        ctr_d = ctr_q[ex_idx];
        if (ex_actual_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'b01;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'b01;
        end
    end

    // Valid/counter update: reset wins; one entry (ex_idx) written per cycle at most
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (ex_valid) begin
            if (ex_is_branch) begin
                if (ex_hit) begin
                    ctr_q[ex_idx] <= ctr_d;
                end else if (ex_actual_taken) begin
                    valid_q[ex_idx] <= 1'b1;
                    ctr_q[ex_idx]   <= 2'b10;
                end
            end else if (ex_hit) begin
                // Non-branch aliasing a BTB entry: drop the stale entry
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

    // Tag/target write on any taken branch (alloc or hit); tag is unchanged on a hit
    always_ff @(posedge clk) begin
        if (rst && upd_br && ex_actual_taken) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= ex_actual_target;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    // Statistics counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (upd_br)     stat_br_q <= stat_br_q + 32'd1;
            if (mispredict) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16): reset state, allocation,
// counter saturation, target rewrite, aliasing/invalidation, stats.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        ex_valid, ex_is_branch;
    logic [31:0] ex_pc, ex_actual_target, ex_pred_target;
    logic        ex_actual_taken, ex_pred_taken;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] stat_branches, stat_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_actual_target(ex_actual_target), .ex_pred_target(ex_pred_target),
        .ex_actual_taken(ex_actual_taken), .ex_pred_taken(ex_pred_taken),
        .mispredict(mispredict), .correct_pc(correct_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed well before the following one
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                            input logic atk, input logic [31:0] at,
                            input logic ptk, input logic [31:0] pt);
        ex_valid = v; ex_is_branch = br; ex_pc = pc;
        ex_actual_taken = atk; ex_actual_target = at;
        ex_pred_taken = ptk; ex_pred_target = pt;
        #1;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fetch_pc = 32'h100;
        // Taken branch during reset: redirect stays combinational, table must not allocate
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        checks++;
        if (mispredict !== 1'b1 || correct_pc !== 32'h200) begin
            errors++;
            $display("FAIL reset_redirect: got mp=%b cpc=%h, want 1 00000200", mispredict, correct_pc);
        end
        tick(); tick();
        rst = 1'b1;
        idle_ex();
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h104) begin
            errors++;
            $display("FAIL reset_lookup: got pt=%b tgt=%h, want 0 00000104", predict_taken, predict_target);
        end
        checks++;
        if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: got %0d/%0d, want 0/0", stat_branches, stat_mispredicts);
        end
        fetch_pc = 32'hFFFF_FFFC; #1;
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: got pt=%b tgt=%h, want 0 00000000", predict_taken, predict_target);
        end
    endtask

    task automatic test_alloc();
        fetch_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        checks++;
        if (mispredict !== 1'b1 || correct_pc !== 32'h200) begin
            errors++;
            $display("FAIL alloc_redirect: got mp=%b cpc=%h, want 1 00000200", mispredict, correct_pc);
        end
        checks++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL alloc_same_cycle: got pt=%b, want 0", predict_taken);
        end
        tick();
        idle_ex();
        checks++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin
            errors++;
            $display("FAIL alloc_lookup: got pt=%b tgt=%h, want 1 00000200", predict_taken, predict_target);
        end
    endtask

    // Entry 0x100 starts at ctr=10
    task automatic test_ctr_sat();
        fetch_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        checks++;
        if (mispredict !== 1'b1 || correct_pc !== 32'h104) begin
            errors++;
            $display("FAIL nt_redirect: got mp=%b cpc=%h, want 1 00000104", mispredict, correct_pc);
        end
        tick();   // ctr 01
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h104) begin
            errors++;
            $display("FAIL nt_first: got pt=%b tgt=%h, want 0 00000104", predict_taken, predict_target);
        end
        checks++;
        if (mispredict !== 1'b0) begin
            errors++;
            $display("FAIL nt_correct_pred: got mp=%b, want 0", mispredict);
        end
        tick();   // ctr 00
        tick();   // ctr stays 00
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();   // ctr 01 if saturated at 00
        idle_ex();
        checks++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL ctr_floor: got pt=%b, want 0", predict_taken);
        end
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();   // ctr 10
        idle_ex();
        checks++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin
            errors++;
            $display("FAIL ctr_rise: got pt=%b tgt=%h, want 1 00000200", predict_taken, predict_target);
        end
    endtask

    task automatic test_target();
        fetch_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        checks++;
        if (mispredict !== 1'b1 || correct_pc !== 32'h300) begin
            errors++;
            $display("FAIL tgt_redirect: got mp=%b cpc=%h, want 1 00000300", mispredict, correct_pc);
        end
        tick();
        idle_ex();
        checks++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h300) begin
            errors++;
            $display("FAIL tgt_rewrite: got pt=%b tgt=%h, want 1 00000300", predict_taken, predict_target);
        end
    endtask

    task automatic test_alias();
        drive_ex(1'b1, 1'b1, 32'h140, 1'b1, 32'h400, 1'b0, 32'h0);
        tick();
        idle_ex();
        fetch_pc = 32'h100; #1;
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h104) begin
            errors++;
            $display("FAIL alias_evict: got pt=%b tgt=%h, want 0 00000104", predict_taken, predict_target);
        end
        fetch_pc = 32'h140; #1;
        checks++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h400) begin
            errors++;
            $display("FAIL alias_alloc: got pt=%b tgt=%h, want 1 00000400", predict_taken, predict_target);
        end
        // Non-branch: actual_taken is ignored
        drive_ex(1'b1, 1'b0, 32'h140, 1'b1, 32'h999, 1'b1, 32'h400);
        checks++;
        if (mispredict !== 1'b1 || correct_pc !== 32'h144) begin
            errors++;
            $display("FAIL nonbr_redirect: got mp=%b cpc=%h, want 1 00000144", mispredict, correct_pc);
        end
        tick();
        idle_ex();
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h144) begin
            errors++;
            $display("FAIL nonbr_invalidate: got pt=%b tgt=%h, want 0 00000144", predict_taken, predict_target);
        end
        // Not-taken miss leaves the table alone (entry still invalid, no allocation)
        drive_ex(1'b1, 1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle_ex();
        checks++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL nt_miss: got pt=%b, want 0", predict_taken);
        end
    endtask

    task automatic test_ex_invalid();
        fetch_pc = 32'h180;
        drive_ex(1'b0, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h0);
        checks++;
        if (mispredict !== 1'b0) begin
            errors++;
            $display("FAIL exinv_mp: got mp=%b, want 0", mispredict);
        end
        tick();
        idle_ex();
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h184) begin
            errors++;
            $display("FAIL exinv_table: got pt=%b tgt=%h, want 0 00000184", predict_taken, predict_target);
        end
    endtask

    task automatic test_stats();
        rst = 1'b0;
        idle_ex();
        tick();
        rst = 1'b1;
        // 3 branches: mispredict, mispredict, correct
        drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        drive_ex(1'b1, 1'b1, 32'h204, 1'b0, 32'h0, 1'b1, 32'h700);
        tick();
        drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h600, 1'b1, 32'h600);
        tick();
        idle_ex();
`ifdef BP_STATS_EN
        checks++;
        if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd2) begin
            errors++;
            $display("FAIL stats_count: got %0d/%0d, want 3/2", stat_branches, stat_mispredicts);
        end
`else
        checks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL stats_tied: got %0d/%0d, want 0/0", stat_branches, stat_mispredicts);
        end
`endif
        // Reset during a mispredicting branch update clears both
        drive_ex(1'b1, 1'b1, 32'h208, 1'b1, 32'h800, 1'b0, 32'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle_ex();
        checks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d/%0d, want 0/0", stat_branches, stat_mispredicts);
        end
        fetch_pc = 32'h208; #1;
        checks++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got pt=%b, want 0", predict_taken);
        end
    endtask

    initial begin
        rst = 1'b0;
        fetch_pc = 32'h0;
        idle_ex();
        tick();
        test_reset();
        test_alloc();
        test_ctr_sat();
        test_target();
        test_alias();
        test_ex_invalid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
